// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: FD-stage hazard unit. Tracks outstanding register writes
// from fixed-latency loads (per-register countdown) and the single
// variable-latency multdiv unit, and produces the FD stall and its cause.
module hazard_scoreboard #(
    parameter int unsigned NUM_REGS  = 32,
    parameter int unsigned REG_BITS  = 5,
    parameter int unsigned LOAD_LAT  = 1,
    parameter int unsigned STORE_FWD = 1
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                fd_valid,
    input  logic [REG_BITS-1:0] fd_rs,
    input  logic [REG_BITS-1:0] fd_rt,
    input  logic                fd_uses_rs,
    input  logic                fd_uses_rt,
    input  logic                fd_is_store,
    input  logic                fd_wr_en,
    input  logic [REG_BITS-1:0] fd_rd,
    input  logic [1:0]          fd_class,
    input  logic                flush,
    input  logic                md_done,
    output logic                stall,
    output logic [1:0]          stall_cause,
    output logic                md_busy,
    output logic [NUM_REGS-1:0] pending
);

    localparam int unsigned CNT_W = 3;

    localparam logic [1:0] CLS_LOAD = 2'b01;
    localparam logic [1:0] CLS_MD   = 2'b10;

    localparam logic [1:0] CAUSE_NONE   = 2'b00;
    localparam logic [1:0] CAUSE_LOAD   = 2'b01;
    localparam logic [1:0] CAUSE_MD_DEP = 2'b10;
    localparam logic [1:0] CAUSE_MD_STR = 2'b11;

    logic [CNT_W-1:0]    cnt_q [NUM_REGS];
    logic [CNT_W-1:0]    cnt_d [NUM_REGS];
    logic                md_busy_q;
    logic                md_busy_d;
    logic [REG_BITS-1:0] md_rd_q;
    logic [REG_BITS-1:0] md_rd_d;

    logic fd_live;
    logic rs_chk;
    logic rt_chk;
    logic rt_fwd_ok;
    logic md_struct;
    logic md_dep;
    logic ld_dep;
    logic issue;
    logic wr_tracked;

    // Hazard detection: combinational from registered state and FD fields
    always_comb begin
        fd_live     = 1'b0;
        rs_chk      = 1'b0;
        rt_chk      = 1'b0;
        rt_fwd_ok   = 1'b0;
        md_struct   = 1'b0;
        md_dep      = 1'b0;
        ld_dep      = 1'b0;
        stall_cause = CAUSE_NONE;

        fd_live = fd_valid & ~flush;
        rs_chk  = fd_uses_rs && (fd_rs != '0);
        rt_chk  = fd_uses_rt && (fd_rt != '0);

        // Store data is read late, so the final load cycle can be forwarded
        rt_fwd_ok = (STORE_FWD != 0) && fd_is_store && (cnt_q[fd_rt] == CNT_W'(1));

        md_struct = fd_live && md_busy_q && (fd_class == CLS_MD);
        md_dep    = fd_live && md_busy_q &&
                    ((rs_chk && (fd_rs == md_rd_q)) ||
                     (rt_chk && (fd_rt == md_rd_q)) ||
                     (fd_wr_en && (fd_rd != '0) && (fd_rd == md_rd_q)));
        ld_dep    = fd_live &&
                    ((rs_chk && (cnt_q[fd_rs] != '0)) ||
                     (rt_chk && !rt_fwd_ok && (cnt_q[fd_rt] != '0)));

        if (md_struct) begin
            stall_cause = CAUSE_MD_STR;
        end else if (md_dep) begin
            stall_cause = CAUSE_MD_DEP;
        end else if (ld_dep) begin
            stall_cause = CAUSE_LOAD;
        end
    end

    assign stall = (stall_cause != CAUSE_NONE);

    // Next-state: load countdowns and multdiv busy/tag
    always_comb begin
        issue      = 1'b0;
        wr_tracked = 1'b0;
        md_busy_d  = md_busy_q;
        md_rd_d    = md_rd_q;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            cnt_d[i] = cnt_q[i];
        end

        issue      = fd_valid & ~flush & ~stall;
        wr_tracked = issue && fd_wr_en && (fd_rd != '0);

        for (int i = 1; i < int'(NUM_REGS); i++) begin
            if (wr_tracked && (fd_class == CLS_LOAD) && (fd_rd == REG_BITS'(i))) begin
                cnt_d[i] = CNT_W'(LOAD_LAT);
            end else if (cnt_q[i] != '0) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
        end
        cnt_d[0] = '0;

        // A multdiv issue is blocked while busy, so it never collides with md_done
        if (wr_tracked && (fd_class == CLS_MD)) begin
            md_busy_d = 1'b1;
            md_rd_d   = fd_rd;
        end else if (md_done) begin
            md_busy_d = 1'b0;
        end
    end

    // State registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                cnt_q[i] <= '0;
            end
            md_busy_q <= 1'b0;
            md_rd_q   <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            md_busy_q <= md_busy_d;
            md_rd_q   <= md_rd_d;
        end
    end

    // Per-register pending view for debug/forwarding consumers
    always_comb begin
        pending = '0;
        for (int i = 1; i < int'(NUM_REGS); i++) begin
            pending[i] = (cnt_q[i] != '0) || (md_busy_q && (md_rd_q == REG_BITS'(i)));
        end
    end

    assign md_busy = md_busy_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: vector table plus hand-written reset sequence across
// three configurations (LL=1/SF=1, LL=3/SF=1, LL=1/SF=0).
module tb_hazard_scoreboard;

    typedef struct packed {
        logic       valid;
        logic [1:0] cls;
        logic       wr;
        logic [4:0] rd;
        logic [4:0] rs;
        logic       urs;
        logic [4:0] rt;
        logic       urt;
        logic       st;
    } ins_t;

    typedef struct {
        int          sel;
        bit          rst;
        ins_t        ins;
        bit          fl;
        bit          done;
        bit          e_stall;
        logic [1:0]  e_cause;
        bit          e_busy;
        logic [31:0] e_pend;
    } vec_t;

    typedef struct {
        int          sel;
        int          idx;
        bit          stall;
        logic [1:0]  cause;
        bit          busy;
        logic [31:0] pend;
    } exp_t;

    logic        clock;
    logic        reset_n;
    logic        fd_valid;
    logic [4:0]  fd_rs;
    logic [4:0]  fd_rt;
    logic        fd_uses_rs;
    logic        fd_uses_rt;
    logic        fd_is_store;
    logic        fd_wr_en;
    logic [4:0]  fd_rd;
    logic [1:0]  fd_class;
    logic        flush;
    logic        md_done;

    logic [2:0]       stall_w;
    logic [2:0][1:0]  cause_w;
    logic [2:0]       busy_w;
    logic [2:0][31:0] pend_w;

    int   n_tests;
    int   n_fail;
    vec_t tbl[$];
    exp_t sb_q[$];

    hazard_scoreboard #(.NUM_REGS(32), .REG_BITS(5), .LOAD_LAT(1), .STORE_FWD(1)) u_a (
        .clock(clock), .reset_n(reset_n), .fd_valid(fd_valid), .fd_rs(fd_rs), .fd_rt(fd_rt),
        .fd_uses_rs(fd_uses_rs), .fd_uses_rt(fd_uses_rt), .fd_is_store(fd_is_store),
        .fd_wr_en(fd_wr_en), .fd_rd(fd_rd), .fd_class(fd_class), .flush(flush),
        .md_done(md_done), .stall(stall_w[0]), .stall_cause(cause_w[0]),
        .md_busy(busy_w[0]), .pending(pend_w[0])
    );

    hazard_scoreboard #(.NUM_REGS(32), .REG_BITS(5), .LOAD_LAT(3), .STORE_FWD(1)) u_b (
        .clock(clock), .reset_n(reset_n), .fd_valid(fd_valid), .fd_rs(fd_rs), .fd_rt(fd_rt),
        .fd_uses_rs(fd_uses_rs), .fd_uses_rt(fd_uses_rt), .fd_is_store(fd_is_store),
        .fd_wr_en(fd_wr_en), .fd_rd(fd_rd), .fd_class(fd_class), .flush(flush),
        .md_done(md_done), .stall(stall_w[1]), .stall_cause(cause_w[1]),
        .md_busy(busy_w[1]), .pending(pend_w[1])
    );

    hazard_scoreboard #(.NUM_REGS(32), .REG_BITS(5), .LOAD_LAT(1), .STORE_FWD(0)) u_c (
        .clock(clock), .reset_n(reset_n), .fd_valid(fd_valid), .fd_rs(fd_rs), .fd_rt(fd_rt),
        .fd_uses_rs(fd_uses_rs), .fd_uses_rt(fd_uses_rt), .fd_is_store(fd_is_store),
        .fd_wr_en(fd_wr_en), .fd_rd(fd_rd), .fd_class(fd_class), .flush(flush),
        .md_done(md_done), .stall(stall_w[2]), .stall_cause(cause_w[2]),
        .md_busy(busy_w[2]), .pending(pend_w[2])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic ins_t nop();
        ins_t t;
        t = '0;
        return t;
    endfunction

    function automatic ins_t alu(int rs, int rt, int rd);
        ins_t t;
        t = '0;
        t.valid = 1'b1; t.wr = 1'b1; t.rd = 5'(rd);
        t.rs = 5'(rs); t.urs = 1'b1; t.rt = 5'(rt); t.urt = 1'b1;
        return t;
    endfunction

    function automatic ins_t ld(int rd);
        ins_t t;
        t = '0;
        t.valid = 1'b1; t.cls = 2'b01; t.wr = 1'b1; t.rd = 5'(rd);
        t.rs = 5'd1; t.urs = 1'b1;
        return t;
    endfunction

    function automatic ins_t st(int rs, int rt);
        ins_t t;
        t = '0;
        t.valid = 1'b1; t.st = 1'b1;
        t.rs = 5'(rs); t.urs = 1'b1; t.rt = 5'(rt); t.urt = 1'b1;
        return t;
    endfunction

    function automatic ins_t md(int rd, int rs, int rt);
        ins_t t;
        t = alu(rs, rt, rd);
        t.cls = 2'b10;
        return t;
    endfunction

    function automatic int unsigned pb(int i);
        return 32'(1) << i;
    endfunction

    function automatic void v(int sel, int rst, ins_t ins, int fl, int done,
                              int es, int ec, int eb, int unsigned ep);
        vec_t r;
        r.sel = sel; r.rst = (rst != 0); r.ins = ins; r.fl = (fl != 0); r.done = (done != 0);
        r.e_stall = (es != 0); r.e_cause = 2'(ec); r.e_busy = (eb != 0); r.e_pend = ep;
        tbl.push_back(r);
    endfunction

    task automatic drive(ins_t t, bit fl, bit done);
        fd_valid    = t.valid;
        fd_class    = t.cls;
        fd_wr_en    = t.wr;
        fd_rd       = t.rd;
        fd_rs       = t.rs;
        fd_uses_rs  = t.urs;
        fd_rt       = t.rt;
        fd_uses_rt  = t.urt;
        fd_is_store = t.st;
        flush       = fl;
        md_done     = done;
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle, queue the expectation, compare at the falling edge
    task automatic apply(int idx, int sel, ins_t t, bit fl, bit done,
                         bit es, logic [1:0] ec, bit eb, logic [31:0] ep);
        exp_t e;
        exp_t g;
        drive(t, fl, done);
        e.sel = sel; e.idx = idx; e.stall = es; e.cause = ec; e.busy = eb; e.pend = ep;
        sb_q.push_back(e);
        @(negedge clock);
        g = sb_q.pop_front();
        check($sformatf("v%0d.u%0d stall", g.idx, g.sel), 32'(stall_w[g.sel]), 32'(g.stall));
        check($sformatf("v%0d.u%0d cause", g.idx, g.sel), 32'(cause_w[g.sel]), 32'(g.cause));
        check($sformatf("v%0d.u%0d md_busy", g.idx, g.sel), 32'(busy_w[g.sel]), 32'(g.busy));
        check($sformatf("v%0d.u%0d pending", g.idx, g.sel), pend_w[g.sel], g.pend);
        @(posedge clock);
        #1;
    endtask

    initial begin
        ins_t t;
        n_tests = 0;
        n_fail  = 0;

        // Hazardous FD contents while reset is held: nothing may stall
        reset_n = 1'b0;
        drive(alu(5, 7, 8), 1'b0, 1'b0);
        #3;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("reset.u%0d stall", d), 32'(stall_w[d]), 32'd0);
            check($sformatf("reset.u%0d md_busy", d), 32'(busy_w[d]), 32'd0);
            check($sformatf("reset.u%0d pending", d), pend_w[d], 32'd0);
        end
        @(posedge clock);
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        // LL=1, SF=1: load-use, store forwarding, invalid/flush/reserved class
        v(0, 1, ld(5),        0, 0, 0, 0, 0, 0);
        v(0, 0, alu(5, 6, 8), 0, 0, 1, 1, 0, pb(5));
        v(0, 0, alu(5, 6, 8), 0, 0, 0, 0, 0, 0);
        v(0, 0, ld(5),        0, 0, 0, 0, 0, 0);
        v(0, 0, st(2, 5),     0, 0, 0, 0, 0, pb(5));
        v(0, 0, ld(5),        0, 0, 0, 0, 0, 0);
        v(0, 0, st(5, 2),     0, 0, 1, 1, 0, pb(5));
        v(0, 0, st(5, 2),     0, 0, 0, 0, 0, 0);
        v(0, 0, ld(5),        0, 0, 0, 0, 0, 0);
        t = alu(5, 6, 8); t.valid = 1'b0;
        v(0, 0, t,            0, 0, 0, 0, 0, pb(5));
        v(0, 0, ld(5),        0, 0, 0, 0, 0, 0);
        v(0, 0, alu(5, 6, 8), 1, 0, 0, 0, 0, pb(5));
        t = alu(1, 2, 6); t.cls = 2'b11;
        v(0, 0, t,            0, 0, 0, 0, 0, 0);
        v(0, 0, alu(6, 6, 8), 0, 0, 0, 0, 0, 0);

        // LL=1, SF=0: store data gets no exemption
        v(2, 1, ld(5),        0, 0, 0, 0, 0, 0);
        v(2, 0, st(2, 5),     0, 0, 1, 1, 0, pb(5));
        v(2, 0, st(2, 5),     0, 0, 0, 0, 0, 0);
        v(2, 0, ld(5),        0, 0, 0, 0, 0, 0);
        v(2, 0, st(5, 2),     0, 0, 1, 1, 0, pb(5));
        v(2, 0, st(5, 2),     0, 0, 0, 0, 0, 0);

        // LL=3: three-cycle stall, r0 destination, store forwarding, reload
        v(1, 1, ld(9),         0, 0, 0, 0, 0, 0);
        v(1, 0, alu(3, 9, 10), 0, 0, 1, 1, 0, pb(9));
        v(1, 0, alu(3, 9, 10), 0, 0, 1, 1, 0, pb(9));
        v(1, 0, alu(3, 9, 10), 0, 0, 1, 1, 0, pb(9));
        v(1, 0, alu(3, 9, 10), 0, 0, 0, 0, 0, 0);
        v(1, 0, ld(0),         0, 0, 0, 0, 0, 0);
        v(1, 0, alu(3, 0, 10), 0, 0, 0, 0, 0, 0);
        v(1, 0, ld(9),         0, 0, 0, 0, 0, 0);
        v(1, 0, st(2, 9),      0, 0, 1, 1, 0, pb(9));
        v(1, 0, st(2, 9),      0, 0, 1, 1, 0, pb(9));
        v(1, 0, st(2, 9),      0, 0, 0, 0, 0, pb(9));
        v(1, 0, nop(),         0, 0, 0, 0, 0, 0);
        v(1, 0, ld(9),         0, 0, 0, 0, 0, 0);
        v(1, 0, nop(),         0, 0, 0, 0, 0, pb(9));
        v(1, 0, ld(9),         0, 0, 0, 0, 0, pb(9));
        v(1, 0, alu(9, 0, 10), 0, 0, 1, 1, 0, pb(9));
        v(1, 0, alu(9, 0, 10), 0, 0, 1, 1, 0, pb(9));
        v(1, 0, alu(9, 0, 10), 0, 0, 1, 1, 0, pb(9));
        v(1, 0, alu(9, 0, 10), 0, 0, 0, 0, 0, 0);

        // Multdiv RAW, WAW, structural, flush, stray md_done
        v(0, 1, md(7, 1, 2),   0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            v(0, 0, alu(7, 2, 8), 0, 0, 1, 2, 1, pb(7));
        end
        v(0, 0, alu(7, 2, 8),  0, 1, 1, 2, 1, pb(7));
        v(0, 0, alu(7, 2, 8),  0, 0, 0, 0, 0, 0);
        v(0, 0, md(7, 1, 2),   0, 0, 0, 0, 0, 0);
        v(0, 0, alu(1, 2, 7),  0, 0, 1, 2, 1, pb(7));
        v(0, 0, alu(1, 2, 7),  0, 1, 1, 2, 1, pb(7));
        v(0, 0, alu(1, 2, 7),  0, 0, 0, 0, 0, 0);
        v(0, 0, md(7, 1, 2),   0, 0, 0, 0, 0, 0);
        v(0, 0, md(11, 1, 2),  0, 0, 1, 3, 1, pb(7));
        v(0, 0, md(11, 7, 2),  0, 0, 1, 3, 1, pb(7));
        v(0, 0, md(11, 7, 2),  0, 1, 1, 3, 1, pb(7));
        v(0, 0, md(11, 7, 2),  0, 0, 0, 0, 0, 0);
        v(0, 0, nop(),         0, 0, 0, 0, 1, pb(11));
        v(0, 0, alu(11, 0, 8), 1, 0, 0, 0, 1, pb(11));
        v(0, 0, nop(),         0, 1, 0, 0, 1, pb(11));
        v(0, 0, nop(),         0, 1, 0, 0, 0, 0);
        v(0, 0, nop(),         0, 0, 0, 0, 0, 0);

        foreach (tbl[i]) begin
            if (tbl[i].rst) begin
                reset_n = 1'b0;
                #2;
                reset_n = 1'b1;
            end
            apply(i, tbl[i].sel, tbl[i].ins, tbl[i].fl, tbl[i].done,
                  tbl[i].e_stall, tbl[i].e_cause, tbl[i].e_busy, tbl[i].e_pend);
        end

        // Asynchronous reset in the middle of a combined multdiv + load stall (LL=3)
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        apply(100, 1, md(7, 1, 2), 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0);
        apply(101, 1, ld(5),       1'b0, 1'b0, 1'b0, 2'b00, 1'b1, pb(7));
        drive(alu(5, 7, 8), 1'b0, 1'b0);
        @(negedge clock);
        check("pre_rst stall", 32'(stall_w[1]), 32'd1);
        check("pre_rst cause", 32'(cause_w[1]), 32'd2);
        check("pre_rst md_busy", 32'(busy_w[1]), 32'd1);
        check("pre_rst pending", pend_w[1], pb(5) | pb(7));
        #1;
        reset_n = 1'b0;
        #1;
        check("mid_rst stall", 32'(stall_w[1]), 32'd0);
        check("mid_rst cause", 32'(cause_w[1]), 32'd0);
        check("mid_rst md_busy", 32'(busy_w[1]), 32'd0);
        check("mid_rst pending", pend_w[1], 32'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(negedge clock);
        check("post_rst stall", 32'(stall_w[1]), 32'd0);
        check("post_rst pending", pend_w[1], 32'd0);
        @(posedge clock);
        #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
